tile_dispatcher: RTL and testbench

TILE_DISPATCHER -- requirements
Module: tile_dispatcher

---
 rtl/tile_dispatcher_pkg.sv | 21 ++
 rtl/tile_dispatcher_fifo.sv | 57 +++++
 rtl/tile_dispatcher.sv | 155 +++++++++++++++
 tb/tb_tile_dispatcher.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_dispatcher_pkg.sv
// Shared definitions for the tile dispatcher: engine FSM encodings,
// queue entry layout and routing constants.
package tile_dispatcher_pkg;

    // Per-engine activity state.
    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_BUSY = 1'b1
    } eng_state_e;

    // Queue entry is {route, tile_id}; route occupies the MSB.
    localparam int   ROUTE_W   = 1;
    localparam logic ROUTE_CNN = 1'b1;
    localparam logic ROUTE_SNN = 1'b0;

    // Total queue entry width for a given tile-ID width.
    function automatic int entry_width(input int id_w);
        return ROUTE_W + id_w;
    endfunction

endpackage

// File: rtl/tile_dispatcher_fifo.sv
// dispatch_fifo: show-ahead synchronous FIFO holding dispatch decisions.
// Head entry is visible combinationally so the dispatcher can decide a pop
// in the same cycle; a push into a full queue is legal when a pop coincides.
module dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tile_dispatcher.sv
// tile_dispatcher: queues CNN/SNN routing decisions, tags them with a tile ID
// and dispatches strictly in order to two engines, one start per cycle.
// Optional macro TILE_DISPATCH_FALLBACK_EN lets an SNN-routed head entry run
// on the CNN engine when SNN is busy and CNN is idle.
module tile_dispatcher
    import tile_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iDecisionValid,
    input  logic                iRouteToCnn,
    output logic                oCnnStart,
    output logic [ID_WIDTH-1:0] oCnnTileId,
    input  logic                iCnnDone,
    output logic                oSnnStart,
    output logic [ID_WIDTH-1:0] oSnnTileId,
    input  logic                iSnnDone,
    output logic                oOverflow,
    output logic [15:0]         oCnnCount,
    output logic [15:0]         oSnnCount,
    output logic                oIdle
);

    localparam int EW = entry_width(ID_WIDTH);

    logic                fifo_full, fifo_empty;
    logic [EW-1:0]       fifo_head;
    logic                push, pop;
    logic                cnn_go, snn_go;
    logic                head_route;
    logic [ID_WIDTH-1:0] head_id;

    eng_state_e          cnn_state_q, cnn_state_d;
    eng_state_e          snn_state_q, snn_state_d;
    logic [ID_WIDTH-1:0] tile_id_q, tile_id_d;
    logic [ID_WIDTH-1:0] cnn_id_q, cnn_id_d;
    logic [ID_WIDTH-1:0] snn_id_q, snn_id_d;
    logic                cnn_start_q, cnn_start_d;
    logic                snn_start_q, snn_start_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         cnn_cnt_q, cnn_cnt_d;
    logic [15:0]         snn_cnt_q, snn_cnt_d;

    assign head_route = fifo_head[EW-1];
    assign head_id    = fifo_head[ID_WIDTH-1:0];

    dispatch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (iClk),
        .rst_ni  (iRst),
        .push_i  (push),
        .data_i  ({iRouteToCnn, tile_id_q}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head-of-line dispatch decision: only the head entry may go, to an idle engine.
    always_comb begin
        cnn_go = 1'b0;
        snn_go = 1'b0;
        if (!fifo_empty) begin
            if (head_route == ROUTE_CNN) begin
                cnn_go = (cnn_state_q == ENG_IDLE);
            end else begin
                snn_go = (snn_state_q == ENG_IDLE);
`ifdef TILE_DISPATCH_FALLBACK_EN
                if (snn_state_q == ENG_BUSY && cnn_state_q == ENG_IDLE) cnn_go = 1'b1;
`endif
            end
        end
    end

    // A full queue still accepts when the head leaves in the same cycle.
    assign pop  = cnn_go | snn_go;
    assign push = iDecisionValid & (~fifo_full | pop);

    // Next-state for engine FSMs, tile tagging, start pulses and counters.
    always_comb begin
        cnn_state_d = cnn_state_q;
        snn_state_d = snn_state_q;
        tile_id_d   = tile_id_q;
        cnn_id_d    = cnn_id_q;
        snn_id_d    = snn_id_q;
        cnn_cnt_d   = cnn_cnt_q;
        snn_cnt_d   = snn_cnt_q;
        cnn_start_d = cnn_go;
        snn_start_d = snn_go;
        overflow_d  = iDecisionValid & ~push;

        if (push) tile_id_d = tile_id_q + 1'b1;

        // Engine goes busy together with its registered start; Done while idle is ignored.
        case (cnn_state_q)
            ENG_IDLE: if (cnn_go)   cnn_state_d = ENG_BUSY;
            ENG_BUSY: if (iCnnDone) cnn_state_d = ENG_IDLE;
        endcase
        case (snn_state_q)
            ENG_IDLE: if (snn_go)   snn_state_d = ENG_BUSY;
            ENG_BUSY: if (iSnnDone) snn_state_d = ENG_IDLE;
        endcase

        if (cnn_go) begin
            cnn_id_d = head_id;
            if (cnn_cnt_q != 16'hFFFF) cnn_cnt_d = cnn_cnt_q + 16'd1;
        end
        if (snn_go) begin
            snn_id_d = head_id;
            if (snn_cnt_q != 16'hFFFF) snn_cnt_d = snn_cnt_q + 16'd1;
        end
    end

    // State registers; reset discards all in-flight engine state.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            cnn_state_q <= ENG_IDLE;
            snn_state_q <= ENG_IDLE;
            tile_id_q   <= '0;
            cnn_id_q    <= '0;
            snn_id_q    <= '0;
            cnn_start_q <= 1'b0;
            snn_start_q <= 1'b0;
            overflow_q  <= 1'b0;
            cnn_cnt_q   <= '0;
            snn_cnt_q   <= '0;
        end else begin
            cnn_state_q <= cnn_state_d;
            snn_state_q <= snn_state_d;
            tile_id_q   <= tile_id_d;
            cnn_id_q    <= cnn_id_d;
            snn_id_q    <= snn_id_d;
            cnn_start_q <= cnn_start_d;
            snn_start_q <= snn_start_d;
            overflow_q  <= overflow_d;
            cnn_cnt_q   <= cnn_cnt_d;
            snn_cnt_q   <= snn_cnt_d;
        end
    end

    assign oCnnStart  = cnn_start_q;
    assign oSnnStart  = snn_start_q;
    assign oCnnTileId = cnn_id_q;
    assign oSnnTileId = snn_id_q;
    assign oOverflow  = overflow_q;
    assign oCnnCount  = cnn_cnt_q;
    assign oSnnCount  = snn_cnt_q;
    assign oIdle      = fifo_empty & (cnn_state_q == ENG_IDLE) & (snn_state_q == ENG_IDLE);

endmodule

// File: tb/tb_tile_dispatcher.sv
// Testbench for tile_dispatcher: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
// Honours TILE_DISPATCH_FALLBACK_EN the same way as the design.
module tb_tile_dispatcher;

    localparam int DEPTH = 4;
    localparam int IDW   = 8;

    logic           iClk = 1'b0;
    logic           iRst = 1'b0;
    logic           iDecisionValid = 1'b0;
    logic           iRouteToCnn = 1'b0;
    logic           iCnnDone = 1'b0;
    logic           iSnnDone = 1'b0;
    logic           oCnnStart, oSnnStart, oOverflow, oIdle;
    logic [IDW-1:0] oCnnTileId, oSnnTileId;
    logic [15:0]    oCnnCount, oSnnCount;

    tile_dispatcher #(.FIFO_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iDecisionValid (iDecisionValid),
        .iRouteToCnn    (iRouteToCnn),
        .oCnnStart      (oCnnStart),
        .oCnnTileId     (oCnnTileId),
        .iCnnDone       (iCnnDone),
        .oSnnStart      (oSnnStart),
        .oSnnTileId     (oSnnTileId),
        .iSnnDone       (iSnnDone),
        .oOverflow      (oOverflow),
        .oCnnCount      (oCnnCount),
        .oSnnCount      (oSnnCount),
        .oIdle          (oIdle)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {route, id}, engine busy flags, expected outputs.
    bit [IDW:0]   mq[$];
    bit           m_cbusy, m_sbusy;
    bit [IDW-1:0] m_id;
    bit           e_cstart, e_sstart, e_ovf;
    bit [IDW-1:0] e_cid, e_sid;
    bit [15:0]    e_ccnt, e_scnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_cbusy = 0; m_sbusy = 0; m_id = '0;
        e_cstart = 0; e_sstart = 0; e_ovf = 0;
        e_cid = '0; e_sid = '0; e_ccnt = '0; e_scnt = '0;
    endfunction

    // One clock edge of behaviour, using the inputs present in that cycle.
    function automatic void model_step(input bit dec, input bit rt, input bit cd, input bit sd);
        bit go_c = 0, go_s = 0, acc;
        bit [IDW:0] h = '0;
        if (mq.size() > 0) begin
            h = mq[0];
            if (h[IDW]) go_c = !m_cbusy;
            else begin
                go_s = !m_sbusy;
`ifdef TILE_DISPATCH_FALLBACK_EN
                if (m_sbusy && !m_cbusy) go_c = 1;
`endif
            end
        end
        acc      = dec && (mq.size() < DEPTH || go_c || go_s);
        e_cstart = go_c;
        e_sstart = go_s;
        e_ovf    = dec && !acc;
        if (go_c) begin
            e_cid = h[IDW-1:0];
            if (e_ccnt != 16'hFFFF) e_ccnt++;
            m_cbusy = 1;
        end else if (cd) m_cbusy = 0;
        if (go_s) begin
            e_sid = h[IDW-1:0];
            if (e_scnt != 16'hFFFF) e_scnt++;
            m_sbusy = 1;
        end else if (sd) m_sbusy = 0;
        if (go_c || go_s) void'(mq.pop_front());
        if (acc) begin
            mq.push_back({rt, m_id});
            m_id++;
        end
    endfunction

    task automatic compare_all();
        chk("cnn_start", oCnnStart, e_cstart);
        chk("snn_start", oSnnStart, e_sstart);
        chk("cnn_id", oCnnTileId, e_cid);
        chk("snn_id", oSnnTileId, e_sid);
        chk("overflow", oOverflow, e_ovf);
        chk("cnn_count", oCnnCount, e_ccnt);
        chk("snn_count", oSnnCount, e_scnt);
        chk("idle", oIdle, (mq.size() == 0 && !m_cbusy && !m_sbusy));
    endtask

    // Drive one cycle of inputs, advance model, compare just after the edge.
    task automatic step(input bit dec, input bit rt, input bit cd, input bit sd);
        iDecisionValid = dec; iRouteToCnn = rt; iCnnDone = cd; iSnnDone = sd;
        @(posedge iClk);
        model_step(dec, rt, cd, sd);
        #1;
        $display("cyc t=%0t dec=%0b rt=%0b cd=%0b sd=%0b | cs=%0b cid=%0d ss=%0b sid=%0d ovf=%0b cc=%0d sc=%0d idle=%0b",
                 $time, dec, rt, cd, sd, oCnnStart, oCnnTileId, oSnnStart, oSnnTileId,
                 oOverflow, oCnnCount, oSnnCount, oIdle);
        compare_all();
        iDecisionValid = 0; iRouteToCnn = 0; iCnnDone = 0; iSnnDone = 0;
    endtask

    // Asynchronous reset asserted mid-cycle, held over an edge, released at negedge.
    task automatic do_reset();
        #2;
        iRst = 0;
        #1;
        model_reset();
        chk("rst_async_idle", oIdle, 1);
        chk("rst_async_cstart", oCnnStart, 0);
        compare_all();
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        compare_all();
        chk("reset_idle", oIdle, 1);
        @(negedge iClk);
        iRst = 1;

        // Single CNN decision on an empty queue: start two cycles later.
        step(1, 1, 0, 0);
        chk("lat_not_yet", oCnnStart, 0);
        step(0, 0, 0, 0);
        chk("lat_start", oCnnStart, 1);
        chk("lat_id", oCnnTileId, 0);
        chk("lat_count", oCnnCount, 1);
        step(0, 0, 1, 0);

        // CNN busy, five back-to-back decisions: the fifth overflows.
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        chk("ovf_pulse", oOverflow, 1);
        step(0, 0, 0, 0);
        chk("ovf_one_cycle", oOverflow, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
            chk("inorder_start", oCnnStart, 1);
            chk("inorder_id", oCnnTileId, 2 + k);
        end
        step(0, 0, 1, 0);

        // Head-of-line blocking: blocked CNN head holds back an SNN entry.
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("hol_snn_held", oSnnStart, 0);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("hol_cnn_go", oCnnStart, 1);
        step(0, 0, 0, 0);
        chk("hol_snn_go", oSnnStart, 1);
        step(0, 0, 1, 1);

        // SNN busy, CNN idle, SNN decision: fallback or wait.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
`ifdef TILE_DISPATCH_FALLBACK_EN
        chk("fb_cnn_start", oCnnStart, 1);
`else
        chk("nofb_cnn_start", oCnnStart, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("nofb_snn_after_done", oSnnStart, 1);
`endif
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);

        // Random traffic, including Done pulses to idle engines.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // Reset with three queued entries and both engines busy.
        do_reset();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        do_reset();
        step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("post_rst_no_cstart", oCnnStart, 0);
            chk("post_rst_no_sstart", oSnnStart, 0);
            chk("post_rst_idle", oIdle, 1);
        end

        // Tile ID wraps after 256 accepted decisions.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
            if (i == 255) chk("wrap_id_255", oSnnTileId, 255);
            if (i == 256) chk("wrap_id_0", oSnnTileId, 0);
            step(0, 0, 0, 1);
        end
        chk("wrap_count", oSnnCount, 257);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
